h_seq_ctrl: RTL and testbench

Sequencer that computes the key-dependent S-box stage of the Twofish h-function for 128-bit keys (k = 2), up to the MDS input. It time-shares one q-permutation unit, selectable between q0 and q1, over all 12 byte lookups (4 bytes × 3 stages). Operands come from the key schedule or round logic over a valid/ready handshake. The pre-MDS 32-bit word is returned on a second valid/ready handshake.

---
 rtl/twofish_pkg.sv | 51 +++++
 rtl/h_seq_ctrl_q_perm_unit.sv | 35 +++
 rtl/h_seq_ctrl.sv | 119 +++++++++++
 tb/tb_h_seq_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/twofish_pkg.sv
// Shared Twofish h-function definitions: q-permutation nibble tables,
// q-select pattern, key-select encoding and sequencer state enum.
package twofish_pkg;

  // Nibble tables, element i holds t[i].
  localparam logic [15:0][3:0] Q0_T0 = 64'h4ACE_95B0_23F6_D718;
  localparam logic [15:0][3:0] Q0_T1 = 64'hD907_6A4F_5321_8BCE;
  localparam logic [15:0][3:0] Q0_T2 = 64'h1742_3F8C_09D6_E5AB;
  localparam logic [15:0][3:0] Q0_T3 = 64'hAC58_03B9_E621_4F7D;
  localparam logic [15:0][3:0] Q1_T0 = 64'h5CA0_4913_E67F_DB82;
  localparam logic [15:0][3:0] Q1_T1 = 64'h809F_5AD6_73C4_B2E1;
  localparam logic [15:0][3:0] Q1_T2 = 64'hF3B2_8DE0_A961_57C4;
  localparam logic [15:0][3:0] Q1_T3 = 64'hA802_F746_ED3C_159B;

  // q select per [stage][byte], 1 = q1; stage 3 row is unused.
  localparam logic [3:0][3:0] QSEL = {
    4'b0000,  // stage 3
    4'b0101,  // stage 2: q1 q0 q1 q0
    4'b1100,  // stage 1: q0 q0 q1 q1
    4'b1010   // stage 0: q0 q1 q0 q1
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    KEY_L1,
    KEY_L0,
    KEY_NONE
  } ksel_e;

  function automatic ksel_e key_sel(
    input logic [1:0] st
  );
    case (st)
      2'd0:    return KEY_L1;
      2'd1:    return KEY_L0;
      default: return KEY_NONE;
    endcase
  endfunction

  function automatic logic [3:0] ror4(
    input logic [3:0] v
  );
    return {v[0], v[3:1]};
  endfunction

endpackage

// File: rtl/h_seq_ctrl_q_perm_unit.sv
// Combinational Twofish q0/q1 byte permutation.
// Ports: x (8b in), sel (0 = q0, 1 = q1), y (8b out).
module q_perm_unit
  import twofish_pkg::*;
(
  input  logic [7:0] x,
  input  logic       sel,
  output logic [7:0] y
);

  logic [15:0][3:0] t0, t1, t2, t3;
  logic [3:0] a0, b0, a1, b1;
  logic [3:0] a2, b2, a3, b3;
  logic [3:0] a4, b4;

  always_comb begin
    t0 = sel ? Q1_T0 : Q0_T0;
    t1 = sel ? Q1_T1 : Q0_T1;
    t2 = sel ? Q1_T2 : Q0_T2;
    t3 = sel ? Q1_T3 : Q0_T3;
    a0 = x[7:4];
    b0 = x[3:0];
    a1 = a0 ^ b0;
    // (8*a) mod 16 keeps only a[0] in the MSB
    b1 = a0 ^ ror4(b0) ^ {a0[0], 3'b000};
    a2 = t0[a1];
    b2 = t1[b1];
    a3 = a2 ^ b2;
    b3 = a2 ^ ror4(b2) ^ {a2[0], 3'b000};
    a4 = t2[a3];
    b4 = t3[b3];
    y  = {b4, a4};
  end

endmodule

// File: rtl/h_seq_ctrl.sv
// Twofish h-function S-box sequencer (k = 2), 12 lookups on one q unit.
// Ports: clk, rst, in_* request handshake, out_* result handshake, busy.
module h_seq_ctrl
  import twofish_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_l0,
  input  logic [31:0] in_l1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic        busy
);

  state_e           state;
  logic [3:0][7:0]  acc;
  logic [3:0][7:0]  key0;
  logic [3:0][7:0]  key1;
  logic [1:0]       stage;
  logic [1:0]       bidx;

  logic [7:0]       q_in;
  logic [7:0]       q_out;
  logic             q_sel;
  logic [7:0]       kbyte;
  logic [3:0][7:0]  acc_nxt;

  always_comb begin
    q_in  = acc[bidx];
    q_sel = QSEL[stage][bidx];
    case (key_sel(stage))
      KEY_L1:  kbyte = key1[bidx];
      KEY_L0:  kbyte = key0[bidx];
      default: kbyte = 8'h00;
    endcase
    acc_nxt       = acc;
    acc_nxt[bidx] = q_out ^ kbyte;
  end

  q_perm_unit u_q (
    .x   (q_in),
    .sel (q_sel),
    .y   (q_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      key0      <= '0;
      key1      <= '0;
      stage     <= '0;
      bidx      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_y     <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            acc      <= in_x;
            key0     <= in_l0;
            key1     <= in_l1;
            stage    <= '0;
            bidx     <= '0;
            state    <= ST_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stage == 2'd3) begin
            // unreachable stage: recover to idle
            state    <= ST_IDLE;
            stage    <= '0;
            bidx     <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            acc  <= acc_nxt;
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              if (stage == 2'd2) begin
                stage     <= '0;
                state     <= ST_DONE;
                out_valid <= 1'b1;
                out_y     <= acc_nxt;
              end else begin
                stage <= stage + 2'd1;
              end
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_y     <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_y     <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_h_seq_ctrl.sv
// Self-checking bench for h_seq_ctrl with a behavioural h-function model.
// Directed steps plus random requests, immediate-assertion checks.
module tb_h_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_l0;
  logic [31:0] in_l1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        busy;

  logic [7:0]  qx;
  logic        qs;
  logic [7:0]  qy;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  h_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_l0     (in_l0),
    .in_l1     (in_l1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .busy      (busy)
  );

  q_perm_unit uq (
    .x   (qx),
    .sel (qs),
    .y   (qy)
  );

  // Tables as published, index order t[0] .. t[15].
  int qt [2][4][16] = '{
    '{
      '{8,1,7,13,6,15,3,2,0,11,5,9,14,12,10,4},
      '{14,12,11,8,1,2,3,5,15,4,10,6,7,0,9,13},
      '{11,10,5,14,6,13,9,0,12,8,15,3,2,4,7,1},
      '{13,7,15,4,1,2,6,14,9,11,3,0,8,5,12,10}
    },
    '{
      '{2,8,11,13,15,7,6,14,3,1,9,4,0,10,12,5},
      '{1,14,2,11,4,12,3,7,6,13,10,5,15,9,0,8},
      '{4,12,7,5,1,6,9,10,0,14,13,8,2,11,3,15},
      '{11,9,5,1,12,3,13,14,6,4,7,15,2,0,8,10}
    }
  };

  int qpat [3][4] = '{'{0,1,0,1}, '{0,0,1,1}, '{1,0,1,0}};

  function automatic int ror(input int v);
    return ((v >> 1) | (v << 3)) & 15;
  endfunction

  function automatic int qf(input int s, input int x);
    int a, b, na, nb;
    a  = x / 16;
    b  = x % 16;
    na = a ^ b;
    nb = a ^ ror(b) ^ ((8 * a) % 16);
    a  = qt[s][0][na];
    b  = qt[s][1][nb];
    na = a ^ b;
    nb = a ^ ror(b) ^ ((8 * a) % 16);
    a  = qt[s][2][na];
    b  = qt[s][3][nb];
    return b * 16 + a;
  endfunction

  function automatic logic [31:0] h_model(
    input logic [31:0] x,
    input logic [31:0] l0,
    input logic [31:0] l1
  );
    int v [4];
    int k;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) v[i] = int'((x >> (8 * i)) & 32'hFF);
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 4; i++) begin
        if (s == 0)      k = int'((l1 >> (8 * i)) & 32'hFF);
        else if (s == 1) k = int'((l0 >> (8 * i)) & 32'hFF);
        else             k = 0;
        v[i] = qf(qpat[s][i], v[i]) ^ k;
      end
    end
    r = '0;
    for (int i = 0; i < 4; i++) r = r | (32'(v[i]) << (8 * i));
    return r;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [31:0] x,
    input logic [31:0] l0,
    input logic [31:0] l1
  );
    logic ir;
    bit   ok;
    ok       = 0;
    in_x     = x;
    in_l0    = l0;
    in_l1    = l1;
    in_valid = 1'b1;
    for (int n = 0; n < 30; n++) begin
      ir = in_ready;
      tick();
      if (ir) begin
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) chk("accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_result(
    input string       tag,
    input logic [31:0] exp,
    input bit          chk_acc
  );
    int lat;
    lat = 41;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (chk_acc && (n == 4 || n == 8))
        chk("acc_zero", 32'(dut.acc), 32'd0);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'd12);
    chk({tag, "_y"}, out_y, exp);
  endtask

  logic [31:0] rx, rl0, rl1, held;
  logic [31:0] expq [$];
  int acc_t [$];
  int res_n, cyc;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_l0     = '0;
    in_l1     = '0;
    out_ready = 1'b1;
    qx        = '0;
    qs        = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", out_y, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    qs = 1'b0; qx = 8'h00; #1; chk("q0_00", 32'(qy), 32'hA9);
    qs = 1'b0; qx = 8'h01; #1; chk("q0_01", 32'(qy), 32'h67);
    qs = 1'b1; qx = 8'h00; #1; chk("q1_00", 32'(qy), 32'h75);
    qs = 1'b1; qx = 8'h01; #1; chk("q1_01", 32'(qy), 32'hF3);
    for (int i = 0; i < 16; i++) begin
      qs = 1'($urandom_range(0, 1));
      qx = 8'($urandom_range(0, 255));
      #1;
      chk("q_rand", 32'(qy), 32'(qf(int'(qs), int'(qx))));
    end

    tick();
    send(32'h0, 32'h7575A9A9, 32'h75A975A9);
    chk("busy_run", 32'(busy), 32'd1);
    wait_result("single", 32'hA975A975, 1);
    chk("single_model", h_model(32'h0, 32'h7575A9A9, 32'h75A975A9),
        32'hA975A975);
    tick();
    chk("single_idle_valid", 32'(out_valid), 32'd0);
    chk("single_idle_y", out_y, 32'd0);
    chk("single_idle_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b0;
    send(32'h0, 32'h7575A9A9, 32'h75A975A9);
    wait_result("bp", 32'hA975A975, 0);
    held = out_y;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      in_x     = 32'hDEADBEEF;
      tick();
      chk("bp_y_stable", out_y, 32'hA975A975);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    tick();
    chk("bp_no_extra_busy", 32'(busy), 32'd0);
    chk("bp_held_y", held, 32'hA975A975);

    rx  = $urandom;
    rl0 = $urandom;
    rl1 = $urandom;
    send(rx, rl0, rl1);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    res_n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) res_n++;
    end
    chk("mid_rst_no_pulse", 32'(res_n), 32'd0);
    rx  = $urandom;
    rl0 = $urandom;
    rl1 = $urandom;
    send(rx, rl0, rl1);
    wait_result("after_rst", h_model(rx, rl0, rl1), 0);
    tick();

    for (int r = 0; r < 6; r++) begin
      rx  = $urandom;
      rl0 = $urandom;
      rl1 = $urandom;
      send(rx, rl0, rl1);
      wait_result("rand", h_model(rx, rl0, rl1), 0);
      tick();
    end

    out_ready = 1'b1;
    in_x      = $urandom;
    in_l0     = $urandom;
    in_l1     = $urandom;
    in_valid  = 1'b1;
    res_n     = 0;
    cyc       = 0;
    while (cyc < 60 && res_n < 2) begin
      if (in_valid && in_ready) begin
        expq.push_back(h_model(in_x, in_l0, in_l1));
        acc_t.push_back(cyc);
      end
      tick();
      cyc++;
      if (acc_t.size() >= 2) in_valid = 1'b0;
      else if (!in_ready) begin
        in_x  = $urandom;
        in_l0 = $urandom;
        in_l1 = $urandom;
      end
      if (out_valid) begin
        res_n++;
        if (expq.size() > 0) chk("b2b_y", out_y, expq.pop_front());
        else chk("b2b_spurious", 32'(out_valid), 32'd0);
      end
    end
    in_valid = 1'b0;
    chk("b2b_results", 32'(res_n), 32'd2);
    if (acc_t.size() == 2)
      chk("b2b_spacing", 32'(acc_t[1] - acc_t[0]), 32'd14);
    else
      chk("b2b_accepts", 32'(acc_t.size()), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
